// File: rtl/fifo_n_if.sv
// fifo_n_if: method-style handshake bundle for the fifo_n elastic buffer.
//
// Handshake rule (applies to enq, deq and clear):
//   An operation takes effect at a posedge only when its _ena and _rdy are
//   both high at that edge. _rdy depends only on registered FIFO state,
//   never on any _ena, so a requester may look at _rdy before raising
//   _ena. An _ena raised while _rdy is low is ignored: no state change
//   and no error.
//
// Signals:
//   in_enq_ena / in_enq_v / in_enq_rdy        enqueue request, data, allowed
//   out_deq_ena / out_deq_rdy                 dequeue request, allowed
//   out_first / out_first_rdy                 head entry data, head valid
//   ctl_clear_ena / ctl_clear_rdy             flush request, always allowed
//   count / almost_full                       occupancy and high-water flag
// Modports:
//   slave  - the FIFO itself
//   master - the producer/consumer side driving the requests
interface fifo_n_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             in_enq_ena;
  logic [WIDTH-1:0] in_enq_v;
  logic             in_enq_rdy;
  logic             out_deq_ena;
  logic             out_deq_rdy;
  logic [WIDTH-1:0] out_first;
  logic             out_first_rdy;
  logic             ctl_clear_ena;
  logic             ctl_clear_rdy;
  logic [CW-1:0]    count;
  logic             almost_full;

  modport slave (
    input  in_enq_ena, in_enq_v, out_deq_ena, ctl_clear_ena,
    output in_enq_rdy, out_deq_rdy, out_first, out_first_rdy,
           ctl_clear_rdy, count, almost_full
  );

  modport master (
    output in_enq_ena, in_enq_v, out_deq_ena, ctl_clear_ena,
    input  in_enq_rdy, out_deq_rdy, out_first, out_first_rdy,
           ctl_clear_rdy, count, almost_full
  );
endinterface

// File: rtl/fifo_n.sv
// fifo_n: parametrised synchronous FIFO (circular buffer of DEPTH x WIDTH).
// Concurrent enqueue and dequeue every cycle when neither full nor empty,
// a flush method, an occupancy count and an almost-full flag.
//
// Ports:
//   CLK   - clock, all state changes on posedge
//   nRST  - synchronous active-low reset; clears pointers, count and storage
//   bus   - fifo_n_if.slave handshake bundle (enq, deq/first, clear, status)
//
// Parameters: WIDTH data bits, DEPTH entries (power of two, >= 2),
// AFULL_LEVEL count at or above which almost_full is raised (1..DEPTH).
// The bus interface must be instantiated with the same WIDTH and DEPTH.
module fifo_n #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic     CLK,
  input  logic     nRST,
  fifo_n_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic enq_rdy, deq_rdy;
  logic enq, deq, clr;

  // Ready terms come from registered count only: full blocks enq even with a
  // same-cycle deq, empty blocks deq even with a same-cycle enq.
  assign enq_rdy = (count_q != FULL_CNT);
  assign deq_rdy = (count_q != '0);

  assign clr = bus.ctl_clear_ena;
  assign enq = bus.in_enq_ena & enq_rdy;
  assign deq = bus.out_deq_ena & deq_rdy;

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (clr) begin
      // Flush wins over any enq/deq in the same cycle.
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (enq) wptr_d = wptr_q + AW'(1);
      if (deq) rptr_d = rptr_q + AW'(1);
      if (enq && !deq)      count_d = count_q + CW'(1);
      else if (deq && !enq) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage is only zeroed by reset; a flush just rewinds the pointers.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (enq && !clr) begin
      mem_q[wptr_q] <= bus.in_enq_v;
    end
  end

  assign bus.in_enq_rdy    = enq_rdy;
  assign bus.out_deq_rdy   = deq_rdy;
  assign bus.out_first_rdy = deq_rdy;
  assign bus.out_first     = mem_q[rptr_q];
  assign bus.ctl_clear_rdy = 1'b1;
  assign bus.count         = count_q;
  assign bus.almost_full   = (count_q >= AFULL_CNT);
endmodule

// File: tb/tb_fifo_n.sv
// tb_fifo_n: self-checking bench for fifo_n (WIDTH=32, DEPTH=4, AFULL=3).
// A vector table drives one request set per cycle; a queue model tracks
// the expected contents and checks head data before each accepted dequeue.
module tb_fifo_n;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int AF = D - 1;
  localparam int CW = $clog2(D + 1);

  // ---------------- clock / reset ----------------
  logic clk;
  logic nrst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fifo_n_if #(.WIDTH(W), .DEPTH(D)) bus ();

  fifo_n #(.WIDTH(W), .DEPTH(D), .AFULL_LEVEL(AF)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  // ---------------- scoreboard / counters ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit inv_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Occupancy must never exceed DEPTH.
  always @(negedge clk) begin
    if (inv_en) chk("count_le_depth", 32'(bus.count <= CW'(D)), 32'd1);
  end

  // ---------------- vector table ----------------
  typedef struct {
    bit          rst;
    bit          enq;
    logic [31:0] data;
    bit          deq;
    bit          clr;
    int          exp_count;
    bit          chk_first;
    logic [31:0] exp_first;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit rst, input bit enq, input logic [31:0] data,
                              input bit deq, input bit clr, input int exp_count,
                              input bit chk_first, input logic [31:0] exp_first);
    vec_t v;
    v.rst = rst; v.enq = enq; v.data = data; v.deq = deq; v.clr = clr;
    v.exp_count = exp_count; v.chk_first = chk_first; v.exp_first = exp_first;
    vecs.push_back(v);
  endfunction

  // ---------------- driver ----------------
  task automatic step(input vec_t v);
    int sz;
    bit enq_ok, deq_ok;
    @(negedge clk);
    nrst              = ~v.rst;
    bus.in_enq_ena    = v.enq;
    bus.in_enq_v      = v.data;
    bus.out_deq_ena   = v.deq;
    bus.ctl_clear_ena = v.clr;
    sz     = exp_q.size();
    enq_ok = v.enq && (sz < D);
    deq_ok = v.deq && (sz > 0);
    // Head data is only meaningful while the model holds something.
    if (sz > 0) chk("head_data", bus.out_first, exp_q[0]);
    @(posedge clk);
    if (v.rst || v.clr) begin
      exp_q.delete();
    end else begin
      if (deq_ok) void'(exp_q.pop_front());
      if (enq_ok) exp_q.push_back(v.data);
    end
    #1;
    sz = exp_q.size();
    chk("count_table", 32'(bus.count), 32'(v.exp_count));
    chk("count_model", 32'(bus.count), 32'(sz));
    chk("enq_rdy",     32'(bus.in_enq_rdy),    32'(sz != D));
    chk("deq_rdy",     32'(bus.out_deq_rdy),   32'(sz != 0));
    chk("first_rdy",   32'(bus.out_first_rdy), 32'(sz != 0));
    chk("almost_full", 32'(bus.almost_full),   32'(sz >= AF));
    chk("clear_rdy",   32'(bus.ctl_clear_rdy), 32'd1);
    if (v.chk_first) chk("first_value", bus.out_first, v.exp_first);
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t v;
    nrst              = 1'b0;
    bus.in_enq_ena    = 1'b0;
    bus.in_enq_v      = '0;
    bus.out_deq_ena   = 1'b0;
    bus.ctl_clear_ena = 1'b0;

    // rst enq data        deq clr cnt chkf first
    add(1, 0, 32'h0,        0, 0, 0, 0, 32'h0);
    add(1, 1, 32'h5A,       1, 0, 0, 0, 32'h0);   // ENA ignored under reset
    add(0, 0, 32'h0,        0, 0, 0, 0, 32'h0);   // three idle cycles
    add(0, 0, 32'h0,        0, 0, 0, 0, 32'h0);
    add(0, 0, 32'h0,        0, 0, 0, 0, 32'h0);
    add(0, 1, 32'h11,       0, 0, 1, 1, 32'h11);  // 1-cycle latency from empty
    add(0, 1, 32'h22,       0, 0, 2, 1, 32'h11);
    add(0, 1, 32'h33,       0, 0, 3, 1, 32'h11);  // almost_full rises
    add(0, 1, 32'h44,       0, 0, 4, 1, 32'h11);  // full
    add(0, 1, 32'h55,       0, 0, 4, 1, 32'h11);  // enq while full ignored
    add(0, 1, 32'h55,       1, 0, 3, 1, 32'h22);  // full: only deq happens
    add(0, 0, 32'h0,        1, 0, 2, 1, 32'h33);
    // Steady state at count 2: pointers wrap twice in 10 cycles.
    for (int i = 0; i < 10; i++)
      add(0, 1, 32'h100 + 32'(i), 1, 0, 2, 0, 32'h0);
    add(0, 0, 32'h0,        1, 0, 1, 1, 32'h109);
    add(0, 0, 32'h0,        1, 0, 0, 0, 32'h0);
    add(0, 0, 32'h0,        1, 0, 0, 0, 32'h0);   // deq while empty ignored
    add(0, 1, 32'hAB,       1, 0, 1, 1, 32'hAB);  // empty: no bypass
    add(0, 1, 32'h01,       0, 0, 2, 1, 32'hAB);
    add(0, 1, 32'h02,       0, 0, 3, 1, 32'hAB);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i]);
      if (i == 1) inv_en = 1'b1;
    end

    // Clear with a same-cycle enq: clear wins, enq dropped.
    v = '{rst:0, enq:1, data:32'h99, deq:0, clr:1, exp_count:0, chk_first:0, exp_first:0};
    step(v);
    v = '{rst:0, enq:1, data:32'h77, deq:0, clr:0, exp_count:1, chk_first:1, exp_first:32'h77};
    step(v);
    v = '{rst:0, enq:1, data:32'h78, deq:0, clr:0, exp_count:2, chk_first:1, exp_first:32'h77};
    step(v);
    v = '{rst:0, enq:1, data:32'h79, deq:0, clr:0, exp_count:3, chk_first:1, exp_first:32'h77};
    step(v);

    // Reset at count 3 with requests active: everything discarded.
    v = '{rst:1, enq:1, data:32'hEE, deq:1, clr:0, exp_count:0, chk_first:0, exp_first:0};
    step(v);
    v = '{rst:0, enq:0, data:32'h0, deq:1, clr:0, exp_count:0, chk_first:0, exp_first:0};
    step(v);
    v = '{rst:0, enq:1, data:32'hC3, deq:0, clr:0, exp_count:1, chk_first:1, exp_first:32'hC3};
    step(v);
    v = '{rst:0, enq:0, data:32'h0, deq:1, clr:0, exp_count:0, chk_first:0, exp_first:0};
    step(v);

    // Short random burst; the queue model checks ordering and occupancy.
    for (int i = 0; i < 40; i++) begin
      v.rst       = 1'b0;
      v.enq       = 1'($urandom_range(0, 1));
      v.data      = $urandom;
      v.deq       = 1'($urandom_range(0, 1));
      v.clr       = ($urandom_range(0, 15) == 0);
      v.chk_first = 1'b0;
      v.exp_first = '0;
      begin
        int n;
        n = exp_q.size();
        if (v.clr) n = 0;
        else begin
          if (v.deq && n > 0 && !(v.enq && n < D)) n = n - 1;
          else if (v.enq && n < D && !(v.deq && n > 0)) n = n + 1;
        end
        v.exp_count = n;
      end
      step(v);
    end

    @(negedge clk);
    inv_en = 1'b0;
    bus.in_enq_ena    = 1'b0;
    bus.out_deq_ena   = 1'b0;
    bus.ctl_clear_ena = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_n.md
Name: fifo_n

Overview:
- Parametrised, multi-entry synchronous FIFO; next generation of the single-entry guarded FIFO.
- Generalises data width and depth, and allows concurrent enqueue and dequeue every cycle.
- Adds a flush method, an occupancy count and an almost-full flag.
- Used as the standard elastic buffer between producer/consumer method interfaces in connect designs.

Parameters:
- WIDTH, 32, data bits per entry (>=1).
- DEPTH, 4, number of entries; power of two, >=2.
- AFULL_LEVEL, DEPTH-1, count at or above which almost_full asserts (1..DEPTH).
- CW, $clog2(DEPTH+1), width of count output (derived, not overridden).

Ports:
- CLK  input  1  clock, all state on posedge.
- nRST  input  1  synchronous active-low reset.
- in$enq__ENA  input  1  enqueue request.
- in$enq$v  input  WIDTH  enqueue data.
- in$enq__RDY  output  1  enqueue allowed (not full).
- out$deq__ENA  input  1  dequeue request.
- out$deq__RDY  output  1  dequeue allowed (not empty).
- out$first  output  WIDTH  head entry data.
- out$first__RDY  output  1  head valid (not empty).
- ctl$clear__ENA  input  1  flush all entries.
- ctl$clear__RDY  output  1  constant 1.
- count  output  CW  current occupancy, 0..DEPTH.
- almost_full  output  1  count >= AFULL_LEVEL.

Behaviour:
- Reset: nRST is synchronous, active-low; clock CLK.
  - While nRST=0 at posedge: rptr=0, wptr=0, count=0, all storage entries=0.
  - Outputs after reset: in$enq__RDY=1, out$deq__RDY=0, out$first__RDY=0, out$first=0, count=0, almost_full=0 (AFULL_LEVEL>=1).
  - Reset asserted mid-operation discards all contents; ENA inputs are ignored that cycle.
- Storage:
  - Circular buffer of DEPTH x WIDTH registers.
  - rptr and wptr are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Ready signals (combinational from registered state only, never from ENA inputs):
  - in$enq__RDY = (count != DEPTH).
  - out$deq__RDY = out$first__RDY = (count != 0).
- Effective operations:
  - enq = in$enq__ENA & in$enq__RDY.
  - deq = out$deq__ENA & out$deq__RDY.
  - ENA while RDY is low is ignored; no state change, no error.
- enq only: mem[wptr] <= in$enq$v; wptr+1; count+1.
- deq only: rptr+1; count-1. Storage is untouched.
- enq and deq same cycle (possible only when 0<count<DEPTH): both pointers advance, count unchanged.
- When full, enq is blocked even if deq is asserted the same cycle (no pass-through).
- When empty, deq is blocked even if enq is asserted the same cycle (no bypass).
- Latency:
  - Data enqueued at edge N appears on out$first after edge N when the FIFO was empty: 1 cycle.
  - out$first = mem[rptr], combinational read of registered state.
- Clear:
  - ctl$clear__ENA at an edge sets rptr=wptr=0, count=0. Storage is not zeroed.
  - Clear has priority over any enq/deq the same cycle; those are dropped.
- out$first value when empty is don't-care for checking. The bench must only check it when out$first__RDY=1.
- almost_full is registered-state derived: (count >= AFULL_LEVEL).
- count never exceeds DEPTH and never underflows. The bench asserts this invariant every cycle.

Test Plan:
- Reset then idle 3 cycles -> count=0, in$enq__RDY=1, out$deq__RDY=0, almost_full=0.
- DEPTH=4: enq 0x11,0x22,0x33,0x44 back-to-back -> count 1,2,3,4; almost_full high after 3rd; in$enq__RDY=0 after 4th; 5th enq 0x55 ignored.
- Full FIFO, enq+deq asserted 1 cycle -> only deq occurs; count=3; out$first changes 0x11->0x22; 0x55 never stored.
- Count=2, simultaneous enq/deq for 10 cycles with incrementing data -> count stays 2; pointers wrap twice; out$first sequence is in exact order with no loss or duplication.
- Empty FIFO, enq 0xAB + deq same cycle -> deq ignored; next cycle count=1, out$first=0xAB.
- Count=3, ctl$clear__ENA with enq 0x99 same cycle -> count=0, out$first__RDY=0; subsequent enq 0x77 -> out$first=0x77.
- Reset asserted with count=3 -> next cycle count=0, all RDYs at reset values.
